// File: rtl/spi_xfer_controller.sv
// rtl/spi_xfer_controller.sv - SPI slave transaction sequencer for shift register, address latch and data memory
module spi_xfer_controller #(
    parameter int width = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       csN,
    input  logic       sclkPosEdge,
    input  logic       sclkNegEdge,
    input  logic       rwBit,
    output logic       srPeripheralClkEdge,
    output logic       srParallelLoad,
    output logic       addrLatchEnable,
    output logic       dmWriteEnable,
    output logic       misoBufferEnable,
    output logic [2:0] state
);

    localparam int cntW = $clog2(width + 1);
    localparam logic [cntW-1:0] fullCount = cntW'(width);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ADDR         = 3'd1,
        GOT_ADDR     = 3'd2,
        READ_LOAD    = 3'd3,
        READ_SHIFT   = 3'd4,
        WRITE_SHIFT  = 3'd5,
        WRITE_COMMIT = 3'd6,
        DONE         = 3'd7
    } state_t;

    state_t          curState;
    logic [cntW-1:0] bitCount;
    logic [cntW-1:0] bitCountNext;

    assign bitCountNext = (bitCount == fullCount) ? bitCount : bitCount + cntW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            curState <= IDLE;
            bitCount <= '0;
        end else if (csN) begin
            curState <= IDLE;
            bitCount <= '0;
        end else begin
            case (curState)
                IDLE: begin
                    curState <= ADDR;
                    bitCount <= '0;
                end
                ADDR: if (sclkPosEdge) begin
                    if (bitCountNext == fullCount) begin
                        curState <= GOT_ADDR;
                        bitCount <= '0;
                    end else begin
                        bitCount <= bitCountNext;
                    end
                end
                GOT_ADDR:  curState <= rwBit ? READ_LOAD : WRITE_SHIFT;
                READ_LOAD: curState <= READ_SHIFT;
                READ_SHIFT: if (sclkPosEdge) begin
                    if (bitCountNext == fullCount) begin
                        curState <= DONE;
                        bitCount <= '0;
                    end else begin
                        bitCount <= bitCountNext;
                    end
                end
                WRITE_SHIFT: if (sclkPosEdge) begin
                    if (bitCountNext == fullCount) begin
                        curState <= WRITE_COMMIT;
                        bitCount <= '0;
                    end else begin
                        bitCount <= bitCountNext;
                    end
                end
                WRITE_COMMIT: curState <= DONE;
                DONE:         curState <= DONE;
                default:      curState <= IDLE;
            endcase
        end
    end

    // A colliding negedge is dropped; the first read negedge (bitCount==0) keeps the loaded MSB on MISO
    always_comb begin
        srPeripheralClkEdge = 1'b0;
        case (curState)
            ADDR, WRITE_SHIFT: srPeripheralClkEdge = sclkPosEdge;
            READ_LOAD:         srPeripheralClkEdge = 1'b1;
            READ_SHIFT:        srPeripheralClkEdge = sclkNegEdge & ~sclkPosEdge & (bitCount != '0);
            default:           srPeripheralClkEdge = 1'b0;
        endcase
    end

    assign srParallelLoad   = (curState == READ_LOAD);
    assign addrLatchEnable  = (curState == GOT_ADDR);
    assign dmWriteEnable    = (curState == WRITE_COMMIT);
    assign misoBufferEnable = (curState == READ_SHIFT);
    assign state            = curState;

endmodule

// File: tb/tb_spi_xfer_controller.sv
// tb/tb_spi_xfer_controller.sv - randomized frame-level check of spi_xfer_controller
module tb_spi_xfer_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       csN;
    logic       sclkPosEdge;
    logic       sclkNegEdge;
    logic       rwBit;
    logic       srPeripheralClkEdge;
    logic       srParallelLoad;
    logic       addrLatchEnable;
    logic       dmWriteEnable;
    logic       misoBufferEnable;
    logic [2:0] state;

    int nCompared   = 0;
    int nMismatched = 0;

    int totShift = 0;
    int totLatch = 0;
    int totLoad  = 0;
    int totWrite = 0;
    int totMiso  = 0;

    spi_xfer_controller #(.width(8)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .csN                 (csN),
        .sclkPosEdge         (sclkPosEdge),
        .sclkNegEdge         (sclkNegEdge),
        .rwBit               (rwBit),
        .srPeripheralClkEdge (srPeripheralClkEdge),
        .srParallelLoad      (srParallelLoad),
        .addrLatchEnable     (addrLatchEnable),
        .dmWriteEnable       (dmWriteEnable),
        .misoBufferEnable    (misoBufferEnable),
        .state               (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (srPeripheralClkEdge)              totShift = totShift + 1;
        if (addrLatchEnable)                  totLatch = totLatch + 1;
        if (srParallelLoad)                   totLoad  = totLoad + 1;
        if (dmWriteEnable)                    totWrite = totWrite + 1;
        if (sclkPosEdge && misoBufferEnable)  totMiso  = totMiso + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        nCompared = nCompared + 1;
        if (got != exp) begin
            nMismatched = nMismatched + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edgePair(input int h, input bit collide, input bit sendNeg);
        sclkPosEdge = 1'b1;
        sclkNegEdge = collide;
        tick();
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        repeat (h) tick();
        if (sendNeg) begin
            sclkNegEdge = 1'b1;
            tick();
            sclkNegEdge = 1'b0;
            repeat (h) tick();
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // k posedges are sent; a full frame also sends the last negedge, overruns in DONE, then ends.
    // Otherwise csN rises where negedge k would have been.
    task automatic runFrame(input int k, input bit rw, input bit full);
        int bShift, bLatch, bLoad, bWrite, bMiso;
        int expShift, expLatch, expLoad, expWrite, expMiso;
        csN   = 1'b0;
        rwBit = rw;
        repeat (3) tick();
        bShift = totShift; bLatch = totLatch; bLoad = totLoad;
        bWrite = totWrite; bMiso = totMiso;
        for (int i = 1; i <= k; i++)
            edgePair($urandom_range(4, 6), ($urandom_range(0, 3) == 0), (i < k) || full);
        if (full) begin
            chk("doneState", int'(state), 7);
            for (int i = 0; i < 10; i++) edgePair(4, 1'b0, 1'b1);
            chk("overrunState", int'(state), 7);
        end
        csN = 1'b1;
        tick();
        chk("csHighIdle", int'(state), 0);

        expLatch = (k >= 8) ? 1 : 0;
        expLoad  = (k >= 8 && rw) ? 1 : 0;
        expWrite = (k >= 16 && !rw) ? 1 : 0;
        expMiso  = rw ? imax(0, imin(k, 16) - 8) : 0;
        if (rw)
            expShift = imin(k, 8) + expLoad + ((k >= 8) ? imax(0, imin(k - 1, 15) - 8) : 0);
        else
            expShift = imin(k, 16);
        chk("shiftPulses", totShift - bShift, expShift);
        chk("addrLatch",   totLatch - bLatch, expLatch);
        chk("parLoad",     totLoad - bLoad,   expLoad);
        chk("writeStrobe", totWrite - bWrite, expWrite);
        chk("misoSamples", totMiso - bMiso,   expMiso);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; csN = 1'b0; rwBit = 1'b1;
        sclkPosEdge = 1'b0; sclkNegEdge = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sclkPosEdge = i[0];
            sclkNegEdge = ~i[0];
            tick();
            chk("resetOutputs", int'({srPeripheralClkEdge, srParallelLoad, addrLatchEnable,
                                      dmWriteEnable, misoBufferEnable}), 0);
            chk("resetState", int'(state), 0);
        end
        sclkPosEdge = 1'b0; sclkNegEdge = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("leaveReset", int'(state), 1);
        csN = 1'b1;
        tick();

        runFrame(16, 1'b0, 1'b1);
        runFrame(16, 1'b1, 1'b1);
        runFrame(12, 1'b0, 1'b0);
        runFrame(16, 1'b0, 1'b1);
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(0, 2) == 0)
                runFrame($urandom_range(1, 16), 1'($urandom_range(0, 1)), 1'b0);
            else
                runFrame(16, 1'($urandom_range(0, 1)), 1'b1);
        end

        csN = 1'b0; rwBit = 1'b1;
        repeat (3) tick();
        for (int i = 1; i <= 11; i++) edgePair(4, 1'b0, i < 11);
        #2;
        chk("misoBeforeReset", int'(misoBufferEnable), 1);
        reset_n = 1'b0;
        #1;
        chk("misoAsyncReset", int'(misoBufferEnable), 0);
        chk("stateAsyncReset", int'(state), 0);
        #2;
        reset_n = 1'b1;
        csN = 1'b1;
        tick();
        chk("idleAfterReset", int'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
